// File: rtl/sdio_bus_sequencer.sv
// SDIO window bus-cycle sequencer on C7M: strobes the register/ROM block,
// inserts wait states, then acknowledges, errors on timeout, or aborts.
module sdio_bus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       C7M,
  input  logic       RESET_n,
  input  logic       SDIO_ACCESS,
  input  logic       RW_n,
  input  logic       AS_CPU_n,
  input  logic [2:0] WAIT_CFG,
  input  logic       SD_READY,
  output logic       ROM_OE_n,
  output logic       SD_WE_n,
  output logic       DTACK_n,
  output logic       BERR_n,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_ERR,
    S_RECOVER
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_d;
  logic [2:0]      wait_cnt, wait_d;
  logic [TO_W-1:0] to_cnt, to_d, to_inc;
  logic            rw_q, rw_d;
  logic            rom_d, we_d, dt_d, be_d, busy_d;

  assign to_inc = (to_cnt == '1) ? to_cnt : to_cnt + 1'b1;

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      to_cnt   <= '0;
      rw_q     <= 1'b1;
      ROM_OE_n <= 1'b1;
      SD_WE_n  <= 1'b1;
      DTACK_n  <= 1'b1;
      BERR_n   <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      to_cnt   <= to_d;
      rw_q     <= rw_d;
      ROM_OE_n <= rom_d;
      SD_WE_n  <= we_d;
      DTACK_n  <= dt_d;
      BERR_n   <= be_d;
      BUSY     <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    wait_d  = wait_cnt;
    to_d    = to_cnt;
    rw_d    = rw_q;
    rom_d   = 1'b1;
    we_d    = 1'b1;
    dt_d    = 1'b1;
    be_d    = 1'b1;
    unique case (state)
      S_IDLE: begin
        if (SDIO_ACCESS) begin
          state_d = S_WAIT;
          rw_d    = RW_n;
          wait_d  = WAIT_CFG;
          to_d    = '0;
          rom_d   = ~RW_n;
          we_d    = RW_n;
        end
      end
      S_WAIT: begin
        // abort beats ack, ack beats timeout
        if (AS_CPU_n) begin
          state_d = S_RECOVER;
        end else if (wait_cnt != 3'd0) begin
          wait_d = wait_cnt - 3'd1;
          to_d   = to_inc;
          rom_d  = ~rw_q;
          we_d   = rw_q;
        end else if (SD_READY) begin
          state_d = S_ACK;
          rom_d   = ~rw_q;
          we_d    = rw_q;
          dt_d    = 1'b0;
        end else if (to_cnt >= TO_LAST) begin
          state_d = S_ERR;
          be_d    = 1'b0;
        end else begin
          to_d  = to_inc;
          rom_d = ~rw_q;
          we_d  = rw_q;
        end
      end
      S_ACK: begin
        if (AS_CPU_n) begin
          state_d = S_RECOVER;
        end else begin
          rom_d = ~rw_q;
          we_d  = rw_q;
          dt_d  = 1'b0;
        end
      end
      S_ERR: begin
        if (AS_CPU_n) state_d = S_RECOVER;
        else          be_d    = 1'b0;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_sdio_bus_sequencer.sv
// Directed bench for sdio_bus_sequencer; outputs packed as
// {ROM_OE_n, SD_WE_n, DTACK_n, BERR_n, BUSY}.
module tb_sdio_bus_sequencer;

  logic       C7M = 1'b0;
  logic       RESET_n = 1'b1;
  logic       SDIO_ACCESS = 1'b0;
  logic       RW_n = 1'b1;
  logic       AS_CPU_n = 1'b1;
  logic [2:0] WAIT_CFG = 3'd0;
  logic       SD_READY = 1'b0;
  logic       ROM_OE_n, SD_WE_n, DTACK_n, BERR_n, BUSY;

  int n_chk = 0;
  int n_ok  = 0;

  localparam logic [4:0] IDLE_O = 5'b11110;
  localparam logic [4:0] RECV_O = 5'b11111;
  localparam logic [4:0] RD_STB = 5'b01111;
  localparam logic [4:0] WR_STB = 5'b10111;
  localparam logic [4:0] RD_ACK = 5'b01011;
  localparam logic [4:0] WR_ACK = 5'b10011;
  localparam logic [4:0] ERR_O  = 5'b11101;

  sdio_bus_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(8)) dut (
    .C7M(C7M),
    .RESET_n(RESET_n),
    .SDIO_ACCESS(SDIO_ACCESS),
    .RW_n(RW_n),
    .AS_CPU_n(AS_CPU_n),
    .WAIT_CFG(WAIT_CFG),
    .SD_READY(SD_READY),
    .ROM_OE_n(ROM_OE_n),
    .SD_WE_n(SD_WE_n),
    .DTACK_n(DTACK_n),
    .BERR_n(BERR_n),
    .BUSY(BUSY)
  );

  always #50 C7M = ~C7M;

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  function automatic logic [4:0] outs();
    return {ROM_OE_n, SD_WE_n, DTACK_n, BERR_n, BUSY};
  endfunction

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic start(input logic rw, input logic [2:0] wc,
                       input logic rdy);
    RW_n        = rw;
    WAIT_CFG    = wc;
    SD_READY    = rdy;
    AS_CPU_n    = 1'b0;
    SDIO_ACCESS = 1'b1;
    tick();
    SDIO_ACCESS = 1'b0;
  endtask

  task automatic finish_cycle(input string tag);
    AS_CPU_n = 1'b1;
    tick();
    chk({tag, "_recover"}, outs(), RECV_O);
    tick();
    chk({tag, "_idle"}, outs(), IDLE_O);
  endtask

  initial begin
    #2 RESET_n = 1'b0;
    #5 chk("reset", outs(), IDLE_O);
    tick();
    RESET_n = 1'b1;
    tick();
    chk("idle_no_access", outs(), IDLE_O);

    // read, zero wait states
    start(1'b1, 3'd0, 1'b1);
    chk("rd0_strobe", outs(), RD_STB);
    tick();
    chk("rd0_dtack", outs(), RD_ACK);
    tick();
    chk("rd0_hold", outs(), RD_ACK);
    finish_cycle("rd0");

    // write, three wait states, RW_n flips mid-cycle
    start(1'b0, 3'd3, 1'b1);
    chk("wr3_strobe", outs(), WR_STB);
    RW_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("wr3_wait%0d", i), outs(), WR_STB);
    end
    tick();
    chk("wr3_dtack", outs(), WR_ACK);
    finish_cycle("wr3");

    // read timeout with SD_READY low
    start(1'b1, 3'd0, 1'b0);
    chk("to_strobe", outs(), RD_STB);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), outs(), RD_STB);
    end
    tick();
    chk("to_berr", outs(), ERR_O);
    tick();
    chk("to_berr_hold", outs(), ERR_O);
    finish_cycle("to");

    // abort during wait states
    start(1'b0, 3'd5, 1'b1);
    tick();
    chk("ab_wait", outs(), WR_STB);
    finish_cycle("ab");

    // ready arrives on the timeout edge: ack wins
    start(1'b1, 3'd0, 1'b0);
    for (int i = 1; i <= 15; i++) tick();
    chk("pr_pre", outs(), RD_STB);
    SD_READY = 1'b1;
    tick();
    chk("pr_ack_wins", outs(), RD_ACK);
    finish_cycle("pr");

    // abort and ready on the same edge: abort wins
    start(1'b1, 3'd0, 1'b1);
    AS_CPU_n = 1'b1;
    tick();
    chk("pa_abort_wins", outs(), RECV_O);
    tick();
    chk("pa_idle", outs(), IDLE_O);

    // reset while in ack
    start(1'b1, 3'd0, 1'b1);
    tick();
    chk("rst_in_ack", outs(), RD_ACK);
    #20 RESET_n = 1'b0;
    #1 chk("rst_async", outs(), IDLE_O);
    #10 RESET_n = 1'b1;
    AS_CPU_n = 1'b1;
    tick();
    chk("rst_no_access", outs(), IDLE_O);
    start(1'b1, 3'd0, 1'b1);
    chk("post_rst_strobe", outs(), RD_STB);
    tick();
    chk("post_rst_dtack", outs(), RD_ACK);
    finish_cycle("post_rst");

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/sdio_bus_sequencer.md
SDIO_BUS_SEQUENCER -- requirements
Module: sdio_bus_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max C7M cycles spent in WAIT before the bus cycle is errored (range 2..255).
REQ-002 Parameter TO_W, default 8, width of the timeout counter.
REQ-003 C7M  input  1  7 MHz clock; all state changes on its rising edge.
REQ-004 RESET_n  input  1  reset RESET_n, asynchronous, active-low.
REQ-005 SDIO_ACCESS  input  1  decoded CPU access to the configured SDIO window (qualified by AS_CPU_n).
REQ-006 RW_n  input  1  CPU direction (1 = read, 0 = write).
REQ-007 AS_CPU_n  input  1  CPU address strobe, active-low.
REQ-008 WAIT_CFG  input  3  minimum wait-state count, 0..7 C7M cycles.
REQ-009 SD_READY  input  1  SD host register block ready, active-high.
REQ-010 ROM_OE_n  output  1  read strobe to the SDIO register/ROM block, active-low.
REQ-011 SD_WE_n  output  1  write strobe to the SDIO register block, active-low.
REQ-012 DTACK_n  output  1  data acknowledge to the CPU, active-low.
REQ-013 BERR_n  output  1  bus error to the CPU, active-low.
REQ-014 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-015 All outputs shall be registered; states: IDLE, WAIT, ACK, ERR, RECOVER.
REQ-016 IDLE: on an edge with SDIO_ACCESS=1 -> WAIT; latch RW_n into rw_q; wait counter <= WAIT_CFG; timeout counter <= 0; ROM_OE_n <= 0 if rw_q read, else SD_WE_n <= 0.
REQ-017 WAIT: wait counter != 0 -> decrement, timeout counter increments.
REQ-018 WAIT: wait counter == 0 and SD_READY=1 -> ACK, DTACK_n <= 0 on that edge, strobe held.
REQ-019 WAIT: wait counter == 0, SD_READY=0, timeout counter == TIMEOUT_CYCLES-1 -> ERR, BERR_n <= 0, both strobes <= 1.
REQ-020 Latency: access sampled at edge N -> strobe low after edge N, DTACK_n low after edge N+1+WAIT_CFG at earliest.
REQ-021 ACK: hold DTACK_n=0 and strobe until AS_CPU_n=1 sampled; then -> RECOVER, DTACK_n, ROM_OE_n, SD_WE_n <= 1 on the same edge.
REQ-022 ERR: hold BERR_n=0 until AS_CPU_n=1 sampled; then -> RECOVER, BERR_n <= 1.
REQ-023 AS_CPU_n=1 sampled in WAIT (aborted cycle) -> RECOVER, strobes <= 1, DTACK_n and BERR_n never asserted.
REQ-024 RECOVER: one cycle, all strobes high, SDIO_ACCESS ignored; unconditionally -> IDLE.
REQ-025 Abort has priority over ACK and ERR transitions in WAIT on the same edge.
REQ-026 ACK has priority over timeout when SD_READY=1 on the timeout edge.
REQ-027 ROM_OE_n and SD_WE_n shall never be low simultaneously; DTACK_n and BERR_n shall never be low simultaneously.
REQ-028 RW_n changes after IDLE exit shall be ignored (rw_q used for the whole cycle).
REQ-029 Timeout counter shall saturate and never wrap.

Reset
REQ-030 RESET_n low shall immediately force state IDLE, ROM_OE_n=1, SD_WE_n=1, DTACK_n=1, BERR_n=1, BUSY=0, counters 0, regardless of clock.
REQ-031 Reset asserted mid-cycle (any state) shall release all strobes asynchronously; after release the first access requires a fresh SDIO_ACCESS sample.

Verification
REQ-032 Read, WAIT_CFG=0, SD_READY=1: access at edge 0 -> ROM_OE_n low after edge 0, DTACK_n low after edge 1; AS negated -> all high next edge, BUSY low one edge later.
REQ-033 Write, WAIT_CFG=3, SD_READY=1: SD_WE_n low after edge 0, DTACK_n low after edge 4, ROM_OE_n stays 1 throughout.
REQ-034 Read, SD_READY=0 held, TIMEOUT_CYCLES=16: BERR_n low exactly when the timeout counter reaches 15 in WAIT, ROM_OE_n high same edge, DTACK_n stays 1.
REQ-035 AS_CPU_n negated during WAIT with WAIT_CFG=5: strobes high next edge, neither DTACK_n nor BERR_n asserted, IDLE after RECOVER.
REQ-036 RESET_n pulsed low while in ACK: all outputs 1 before next C7M edge; back-to-back access after reset completes normally.
